// File: rtl/exec_if.sv
// Issue/result bundle between register_manager, the execute stage and pc_control.
// The master drives decoded ops; the slave (exec_unit) returns write-back and redirect.
interface exec_if #(
    parameter int unsigned xlen = 32
);
    logic            valid_i;
    logic            ok_o;
    logic [1:0]      unit_i;
    logic [2:0]      sub_unit_i;
    logic [3:0]      sel_i;
    logic            imm_i;
    logic [xlen-1:0] rs1_i;
    logic [xlen-1:0] rs2_i;
    logic [4:0]      rd_i;
    logic [xlen-1:0] immediate_i;
    logic [xlen-1:0] pc_i;
    logic            flush_i;
    logic            res_v;
    logic [4:0]      res_adr;
    logic [xlen-1:0] res_data;
    logic            alu_target_valide;
    logic [xlen-1:0] alu_target;

    modport master (
        output valid_i, unit_i, sub_unit_i, sel_i, imm_i, rs1_i, rs2_i, rd_i,
               immediate_i, pc_i, flush_i,
        input  ok_o, res_v, res_adr, res_data, alu_target_valide, alu_target
    );

    modport slave (
        input  valid_i, unit_i, sub_unit_i, sel_i, imm_i, rs1_i, rs2_i, rd_i,
               immediate_i, pc_i, flush_i,
        output ok_o, res_v, res_adr, res_data, alu_target_valide, alu_target
    );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU and branch/JALR unit plus an iterative MUL/DIV
// that takes xlen cycles on operand magnitudes and fixes the sign when done.
module exec_unit #(
    parameter int unsigned xlen = 32
) (
    input logic   clk,
    input logic   rst_n,
    exec_if.slave bus
);

    localparam int unsigned CntW = $clog2(xlen);

    localparam logic [1:0] UnitAlu    = 2'd0;
    localparam logic [1:0] UnitBranch = 2'd1;
    localparam logic [1:0] UnitMulDiv = 2'd2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [2*xlen-1:0] acc_q, acc_d;
    logic [2*xlen-1:0] mcand_q, mcand_d;
    logic [xlen-1:0]   opa_q, opa_d;
    logic [xlen-1:0]   divisor_q, divisor_d;
    logic [xlen-1:0]   dividend_q, dividend_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              neg_q, neg_d;
    logic              div_zero_q, div_zero_d;

    logic              res_v_q, res_v_d;
    logic [4:0]        res_adr_q, res_adr_d;
    logic [xlen-1:0]   res_data_q, res_data_d;
    logic              tgt_v_q, tgt_v_d;
    logic [xlen-1:0]   tgt_q, tgt_d;

    logic              accept;
    logic              unused_sel;

    assign accept     = bus.valid_i && (state_q == StIdle) && !bus.flush_i;
    assign unused_sel = ^bus.sel_i[3:2];

    // ------------------------------------------------------------------ ALU
    logic [xlen-1:0] op2;
    logic [4:0]      shamt;
    logic [xlen-1:0] alu_res;

    always_comb begin
        op2     = bus.imm_i ? bus.immediate_i : bus.rs2_i;
        shamt   = op2[4:0];
        alu_res = '0;
        unique case (bus.sub_unit_i)
            3'b000: alu_res = (bus.sel_i[0] && !bus.imm_i) ? bus.rs1_i - op2
                                                            : bus.rs1_i + op2;
            3'b001: alu_res = bus.rs1_i << shamt;
            3'b010: alu_res = {{(xlen-1){1'b0}}, $signed(bus.rs1_i) < $signed(op2)};
            3'b011: alu_res = {{(xlen-1){1'b0}}, bus.rs1_i < op2};
            3'b100: alu_res = bus.rs1_i ^ op2;
            3'b101: alu_res = bus.sel_i[0] ? $unsigned($signed(bus.rs1_i) >>> shamt)
                                           : bus.rs1_i >> shamt;
            3'b110: alu_res = bus.rs1_i | op2;
            3'b111: alu_res = bus.rs1_i & op2;
        endcase
    end

    // --------------------------------------------------------------- Branch
    logic            br_taken;
    logic [xlen-1:0] br_tgt;
    logic [xlen-1:0] jalr_sum;
    logic [xlen-1:0] jalr_tgt;
    logic [xlen-1:0] link;

    always_comb begin
        br_taken = 1'b0;
        unique case (bus.sub_unit_i)
            3'b000:         br_taken = bus.rs1_i == bus.rs2_i;
            3'b001:         br_taken = bus.rs1_i != bus.rs2_i;
            3'b100:         br_taken = $signed(bus.rs1_i) < $signed(bus.rs2_i);
            3'b101:         br_taken = $signed(bus.rs1_i) >= $signed(bus.rs2_i);
            3'b110:         br_taken = bus.rs1_i < bus.rs2_i;
            3'b111:         br_taken = bus.rs1_i >= bus.rs2_i;
            3'b010, 3'b011: br_taken = 1'b0;
        endcase
        br_tgt   = bus.pc_i + bus.immediate_i;
        jalr_sum = bus.rs1_i + bus.immediate_i;
        jalr_tgt = {jalr_sum[xlen-1:1], 1'b0};
        link     = bus.pc_i + xlen'(4);
    end

    // -------------------------------------------------- MUL/DIV operand prep
    logic            a_signed, b_signed;
    logic            a_neg, b_neg;
    logic [xlen-1:0] a_mag, b_mag;

    always_comb begin
        a_signed = (bus.sub_unit_i == 3'b000) || (bus.sub_unit_i == 3'b001) ||
                   (bus.sub_unit_i == 3'b010) || (bus.sub_unit_i == 3'b100) ||
                   (bus.sub_unit_i == 3'b110);
        b_signed = (bus.sub_unit_i == 3'b000) || (bus.sub_unit_i == 3'b001) ||
                   (bus.sub_unit_i == 3'b100) || (bus.sub_unit_i == 3'b110);
        a_neg    = a_signed && bus.rs1_i[xlen-1];
        b_neg    = b_signed && bus.rs2_i[xlen-1];
        a_mag    = a_neg ? -bus.rs1_i : bus.rs1_i;
        b_mag    = b_neg ? -bus.rs2_i : bus.rs2_i;
    end

    // ------------------------------------------------ MUL/DIV iteration step
    logic [2*xlen-1:0] mul_acc_nx;
    logic [2*xlen-1:0] md_prod;
    logic [xlen:0]     rem_sh;
    logic [xlen:0]     div_diff;
    logic              div_qbit;
    logic [xlen-1:0]   div_rem_nx, div_quo_nx;
    logic [xlen-1:0]   md_quo, md_rem;
    logic [xlen-1:0]   md_res;

    always_comb begin
        mul_acc_nx = opa_q[0] ? acc_q + mcand_q : acc_q;
        // Restoring step: shift the next dividend bit in, subtract if it fits.
        rem_sh     = {acc_q[xlen-1:0], opa_q[xlen-1]};
        div_diff   = rem_sh - {1'b0, divisor_q};
        div_qbit   = ~div_diff[xlen];
        div_rem_nx = div_qbit ? div_diff[xlen-1:0] : rem_sh[xlen-1:0];
        div_quo_nx = {opa_q[xlen-2:0], div_qbit};
        md_prod    = neg_q ? -mul_acc_nx : mul_acc_nx;
        md_quo     = neg_q ? -div_quo_nx : div_quo_nx;
        md_rem     = neg_q ? -div_rem_nx : div_rem_nx;
        md_res     = '0;
        unique case (op_q)
            3'b000:                 md_res = md_prod[xlen-1:0];
            3'b001, 3'b010, 3'b011: md_res = md_prod[2*xlen-1:xlen];
            3'b100, 3'b101:         md_res = div_zero_q ? '1 : md_quo;
            3'b110, 3'b111:         md_res = div_zero_q ? dividend_q : md_rem;
        endcase
    end

    // ------------------------------------------------------ Control / next
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        opa_d      = opa_q;
        divisor_d  = divisor_q;
        dividend_d = dividend_q;
        op_d       = op_q;
        rd_d       = rd_q;
        neg_d      = neg_q;
        div_zero_d = div_zero_q;
        res_v_d    = 1'b0;
        res_adr_d  = res_adr_q;
        res_data_d = res_data_q;
        tgt_v_d    = 1'b0;
        tgt_d      = tgt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    case (bus.unit_i)
                        UnitAlu: begin
                            res_v_d    = bus.rd_i != 5'd0;
                            res_adr_d  = bus.rd_i;
                            res_data_d = alu_res;
                        end
                        UnitBranch: begin
                            if (bus.sel_i[1]) begin
                                tgt_v_d    = 1'b1;
                                tgt_d      = jalr_tgt;
                                res_v_d    = bus.rd_i != 5'd0;
                                res_adr_d  = bus.rd_i;
                                res_data_d = link;
                            end else if (br_taken) begin
                                tgt_v_d = 1'b1;
                                tgt_d   = br_tgt;
                            end
                        end
                        UnitMulDiv: begin
                            state_d    = StBusy;
                            cnt_d      = '0;
                            acc_d      = '0;
                            mcand_d    = {{xlen{1'b0}}, a_mag};
                            opa_d      = bus.sub_unit_i[2] ? a_mag : b_mag;
                            divisor_d  = b_mag;
                            dividend_d = bus.rs1_i;
                            op_d       = bus.sub_unit_i;
                            rd_d       = bus.rd_i;
                            // REM/REMU take the dividend sign; everything else the XOR.
                            neg_d      = (bus.sub_unit_i[2] && bus.sub_unit_i[1]) ? a_neg
                                                                                  : a_neg ^ b_neg;
                            div_zero_d = bus.rs2_i == '0;
                        end
                        default: ;
                    endcase
                end
            end
            StBusy: begin
                if (bus.flush_i) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                    if (op_q[2]) begin
                        acc_d = {{xlen{1'b0}}, div_rem_nx};
                        opa_d = div_quo_nx;
                    end else begin
                        acc_d   = mul_acc_nx;
                        mcand_d = mcand_q << 1;
                        opa_d   = opa_q >> 1;
                    end
                    if (cnt_q == CntW'(xlen - 1)) begin
                        state_d    = StDone;
                        res_v_d    = rd_q != 5'd0;
                        res_adr_d  = rd_q;
                        res_data_d = md_res;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            opa_q      <= '0;
            divisor_q  <= '0;
            dividend_q <= '0;
            op_q       <= '0;
            rd_q       <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            res_v_q    <= 1'b0;
            res_adr_q  <= '0;
            res_data_q <= '0;
            tgt_v_q    <= 1'b0;
            tgt_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            opa_q      <= opa_d;
            divisor_q  <= divisor_d;
            dividend_q <= dividend_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
            neg_q      <= neg_d;
            div_zero_q <= div_zero_d;
            res_v_q    <= res_v_d;
            res_adr_q  <= res_adr_d;
            res_data_q <= res_data_d;
            tgt_v_q    <= tgt_v_d;
            tgt_q      <= tgt_d;
        end
    end

    assign bus.ok_o              = state_q == StIdle;
    assign bus.res_v             = res_v_q;
    assign bus.res_adr           = res_adr_q;
    assign bus.res_data          = res_data_q;
    assign bus.alu_target_valide = tgt_v_q;
    assign bus.alu_target        = tgt_q;

endmodule
